// File: rtl/scaler_apply_pkg.sv
// scaler_apply_pkg: shared network widths and FSM state encoding for the scaler apply stage
package scaler_apply_pkg;
    localparam int DEF_ACC_WIDTH    = 16;
    localparam int DEF_SCALER_WIDTH = 32;
    localparam int DEF_FRAC_BITS    = 16;
    localparam int DEF_OUT_WIDTH    = 8;
    localparam int DEF_NUM_OUT      = 64;
    localparam int DEF_SCALER_LAT   = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SCL,
        RUN,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/scaler_round_sat.sv
// scaler_round_sat: round-half-up shift, optional relu and saturation of a fixed-point product
module scaler_round_sat #(
    parameter int PW        = 48,
    parameter int FRAC_BITS = 16,
    parameter int OUT_WIDTH = 8,
    parameter int RELU_EN   = 1
)(
    input  logic signed [PW-1:0]        prod,
    output logic signed [OUT_WIDTH-1:0] res
);
    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);
    localparam logic signed [PW-1:0] MAXV = (PW'(1) << (OUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MINV = -(PW'(1) << (OUT_WIDTH - 1));

    logic signed [PW-1:0] sum, rnd, cl;

    always_comb begin
        sum = prod + HALF;
        rnd = sum >>> FRAC_BITS;
        cl  = (RELU_EN != 0 && rnd < 0) ? '0 : rnd;
        res = cl > MAXV ? MAXV[OUT_WIDTH-1:0] : cl < MINV ? MINV[OUT_WIDTH-1:0] : cl[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/scaler_apply.sv
// scaler_apply: applies the latched per-layer scaler to the accumulator stream through a 3-stage pipeline
module scaler_apply
    import scaler_apply_pkg::*;
#(
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int SCALER_WIDTH = DEF_SCALER_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int NUM_OUT      = DEF_NUM_OUT,
    parameter int SCALER_LAT   = DEF_SCALER_LAT,
    parameter int RELU_EN      = 1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        layer_start,
    input  logic [SCALER_WIDTH-1:0]     scaler_in,
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);
    localparam int PW = ACC_WIDTH + SCALER_WIDTH;
    localparam int CW = $clog2(NUM_OUT + 1);
    localparam int WW = $clog2(SCALER_LAT + 1);

    state_t state, state_n;
    logic [WW-1:0] wait_cnt;
    logic [CW-1:0] in_cnt, out_cnt;
    logic signed [SCALER_WIDTH-1:0] scl_reg;
    logic signed [ACC_WIDTH-1:0] s1;
    logic signed [PW-1:0] prod;
    logic signed [OUT_WIDTH-1:0] res;
    logic v1, v2, pipe_en, acc_fire, out_fire, scl_last;

    assign pipe_en   = !out_valid || out_ready;
    assign acc_ready = state == RUN && pipe_en && in_cnt < CW'(NUM_OUT);
    assign acc_fire  = acc_valid && acc_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && out_cnt == CW'(NUM_OUT - 1);
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign scl_last  = wait_cnt == WW'(SCALER_LAT - 1);

    scaler_round_sat #(
        .PW(PW),
        .FRAC_BITS(FRAC_BITS),
        .OUT_WIDTH(OUT_WIDTH),
        .RELU_EN(RELU_EN)
    ) u_round_sat (
        .prod(prod),
        .res(res)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = layer_start ? WAIT_SCL : IDLE;
            WAIT_SCL: state_n = scl_last ? RUN : WAIT_SCL;
            RUN:      state_n = (in_cnt == CW'(NUM_OUT) || (acc_fire && in_cnt == CW'(NUM_OUT - 1))) ? DRAIN : RUN;
            DRAIN:    state_n = (out_fire && out_last) ? DONE : DRAIN;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            scl_reg   <= '0;
            s1        <= '0;
            prod      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= state == WAIT_SCL ? wait_cnt + 1'b1 : '0;
            if (state == WAIT_SCL && scl_last)
                scl_reg <= scaler_in;
            if (state == IDLE)
                in_cnt <= '0;
            else if (acc_fire)
                in_cnt <= in_cnt + 1'b1;
            if (out_fire)
                out_cnt <= out_last ? '0 : out_cnt + 1'b1;
            if (pipe_en) begin
                v1        <= acc_fire;
                v2        <= v1;
                out_valid <= v2;
                if (acc_fire)
                    s1 <= acc_in;
                if (v1)
                    prod <= PW'(s1) * PW'(scl_reg);
                if (v2)
                    out_data <= res;
            end
        end
    end
endmodule

// File: doc/scaler_apply.md
Name: scaler_apply

Overview:
- Downstream consumer of the per-layer scaler stage: takes the 32-bit fixed-point scaler that stage presents and applies it to the stream of signed accumulator results from the ternary PE array.
- Per element: multiply, round, optional ReLU, saturate, then emit an OUT_WIDTH activation with valid/ready to the output buffer writer.
- One layer pass = NUM_OUT elements, then a done pulse.

Parameters:
- ACC_WIDTH, 16, signed accumulator input width.
- SCALER_WIDTH, 32, signed scaler width; Q(SCALER_WIDTH-FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 16, fractional bits of the scaler.
- OUT_WIDTH, 8, signed output activation width.
- NUM_OUT, 64, elements per layer pass (>=1).
- SCALER_LAT, 3, cycles from layer_start until the scaler stage output is stable.
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- layer_start  in  1  one-cycle pulse; the same cycle the scaler stage's state goes high.
- scaler_in  in  SCALER_WIDTH  scaler from the scaler stage; held stable once loaded.
- acc_in  in  ACC_WIDTH  signed accumulator value.
- acc_valid  in  1  acc_in valid.
- acc_ready  out  1  element accepted when acc_valid && acc_ready.
- out_data  out  OUT_WIDTH  signed scaled activation.
- out_valid  out  1  out_data valid; held with data stable until out_ready.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the NUM_OUT-th output.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, pipeline valids cleared, counters 0. Outputs acc_ready, out_valid, out_last, busy, done = 0; out_data = 0; latched scaler = 0. Reset mid-pass aborts immediately; partial results are discarded and done does not pulse.
- FSM:
  - IDLE: on layer_start -> WAIT_SCL, wait counter=0.
  - WAIT_SCL: counts SCALER_LAT cycles; on the last one latches scaler_in into scl_reg -> RUN.
  - RUN: accepts inputs; when in_cnt reaches NUM_OUT -> DRAIN.
  - DRAIN: waits until the last output handshake -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - layer_start outside IDLE is ignored.
- Pipeline stall: pipe_en = !out_valid || out_ready. All three stages advance only when pipe_en=1.
- acc_ready = (state==RUN) && pipe_en && (in_cnt < NUM_OUT). It is combinational from registered state and out_ready.
- in_cnt increments on each input handshake. Simultaneous acceptance of the last input and the RUN->DRAIN transition is legal.
- Pipeline stages:
  - S1 registers acc_in.
  - S2 registers product = signed(acc) * signed(scl_reg), width ACC_WIDTH+SCALER_WIDTH.
  - S3 computes rounded = (product + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift; round half toward +inf). If RELU_EN and rounded<0, result = 0. Result then saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and registers into out_data/out_valid.
- Latency: 3 cycles from input handshake to out_valid with out_ready held high. Throughput 1 element/cycle.
- Backpressure: out_valid=1 with out_ready=0 freezes all stages; no data lost or duplicated.
- out_cnt increments per output handshake. out_last = out_valid && (out_cnt==NUM_OUT-1). out_cnt wraps to 0 on the last handshake.
- scl_reg is constant for the whole pass; changes on scaler_in after the latch are ignored.

Decomposition:
- Shared package/header (network parameters): ACC_WIDTH, SCALER_WIDTH, FRAC_BITS, OUT_WIDTH, NUM_OUT defaults, and FSM state encodings.
- One sub-module: scaler_round_sat. It is the combinational round + ReLU + saturate on the product; parameterised by product width, FRAC_BITS, OUT_WIDTH and RELU_EN, and unit-testable alone.
- FSM, counters and pipeline registers stay in scaler_apply.

Test Plan:
- Identity, NUM_OUT=4, RELU_EN=0: layer_start; scaler_in=0x00010000 stable by cycle 3. acc stream 5,-7,0,127 with out_ready=1 -> out 5,-7,0,127. First out_valid 3 cycles after first accept; out_last on 4th; done one cycle after.
- Rounding, scaler=0x00008000 (0.5), RELU_EN=0: acc 3,-3,1,-1 -> 2,-1,1,0. With RELU_EN=1 -> 2,0,1,0.
- Saturation, scaler=0x00010000: acc 1000 -> 127; acc -1000 -> -128 (RELU_EN=0) or 0 (RELU_EN=1). Scaler=0xFFFF0000 (-1.0), acc 128 -> -128.
- Backpressure: out_ready toggled 1,0,0,1,0,1... during a NUM_OUT=8 pass with continuous acc_valid. Every output appears exactly once in order; out_data stable while stalled; acc_ready low whenever out_valid && !out_ready.
- Scaler latch timing: scaler_in changes to a new value 2 cycles after the latch -> all outputs use the old value. layer_start pulse during RUN -> ignored; busy stays 1.
- Reset mid-pass: rst high for 1 cycle after 2 of 4 outputs -> all outputs 0, state IDLE, no done. A fresh layer_start then completes a full 4-element pass correctly.
